// File: rtl/div_seq_if.sv
// Request, result and shared-ALU signals of the sequential divider.
// The slave modport is the divider; master is whoever issues requests and owns the ALU.
interface div_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            start_valid;
  logic            start_ready;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            is_signed;
  logic            want_rem;
  logic            flush;
  logic            res_valid;
  logic            res_ready;
  logic [XLEN-1:0] res;
  logic            alu_req;
  logic            alu_gnt;
  logic [5:0]      alu_opc;
  logic            alu_imm;
  logic [XLEN-1:0] alu_op1;
  logic [XLEN-1:0] alu_op2;
  logic [XLEN-1:0] alu_res;
  logic [1:0]      alu_cmp;

  modport slave (
    input  start_valid, dividend, divisor, is_signed, want_rem, flush,
           res_ready, alu_gnt, alu_res, alu_cmp,
    output start_ready, res_valid, res, alu_req, alu_opc, alu_imm,
           alu_op1, alu_op2
  );

  modport master (
    output start_valid, dividend, divisor, is_signed, want_rem, flush,
           res_ready, alu_gnt, alu_res, alu_cmp,
    input  start_ready, res_valid, res, alu_req, alu_opc, alu_imm,
           alu_op1, alu_op2
  );
endinterface

// File: rtl/div_seq.sv
// Restoring radix-2 divider that borrows a shared ALU for its compare and
// subtract steps; one quotient bit per 1-2 granted ALU cycles.
module div_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  div_seq_if.slave bus
);

  localparam int unsigned IW     = $clog2(XLEN);
  localparam int unsigned CMP_EQ = 0;
  localparam int unsigned CMP_LT = 1;
  localparam logic [5:0]  OPC_SUB = 6'h04;
  localparam logic [5:0]  OPC_CMP = 6'h05;

  typedef enum logic [2:0] {IDLE, CMP, SUB, FIX, DONE} state_t;

  state_t          state;
  logic [XLEN-1:0] dvd;
  logic [XLEN-1:0] dsr;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [IW-1:0]   i;
  logic            neg_q;
  logic            neg_r;
  logic            want_rem_q;

  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic [XLEN-1:0] step_rem;
  logic            step_qbit;
  logic [IW-1:0]   nxt_i;
  logic [XLEN-1:0] nxt_shift;
  logic            nxt_carry;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic            cmp_lt;

  assign bus.start_ready = (state == IDLE);

  // The ALU command is registered, so alu_op1 already holds the shifted
  // partial remainder of the bit in flight; the next bit's command is
  // prepared from the step result on the same edge that retires this one.
  always_comb begin
    a_abs     = (bus.is_signed && bus.dividend[XLEN-1]) ? -bus.dividend : bus.dividend;
    b_abs     = (bus.is_signed && bus.divisor[XLEN-1])  ? -bus.divisor  : bus.divisor;
    step_rem  = (state == SUB) ? bus.alu_res : bus.alu_op1;
    step_qbit = (state == SUB);
    nxt_i     = i - IW'(1);
    nxt_shift = {step_rem[XLEN-2:0], dvd[nxt_i]};
    nxt_carry = step_rem[XLEN-1];
    q_fix     = neg_q ? -quo : quo;
    r_fix     = neg_r ? -rem : rem;
    // EQ is implied by "not LT"; only a strict less-than skips the subtract
    cmp_lt    = bus.alu_cmp[CMP_LT] && !bus.alu_cmp[CMP_EQ];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      dvd           <= '0;
      dsr           <= '0;
      rem           <= '0;
      quo           <= '0;
      i             <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      want_rem_q    <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res       <= '0;
      bus.alu_req   <= 1'b0;
      bus.alu_opc   <= '0;
      bus.alu_imm   <= 1'b0;
      bus.alu_op1   <= '0;
      bus.alu_op2   <= '0;
    end else if (bus.flush) begin
      state         <= IDLE;
      bus.alu_req   <= 1'b0;
      bus.res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            dvd        <= a_abs;
            dsr        <= b_abs;
            neg_q      <= bus.is_signed && (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]);
            neg_r      <= bus.is_signed && bus.dividend[XLEN-1];
            want_rem_q <= bus.want_rem;
            i          <= IW'(XLEN - 1);
            if (bus.divisor == '0) begin
              rem           <= bus.dividend;
              quo           <= '1;
              bus.res       <= bus.want_rem ? bus.dividend : '1;
              bus.res_valid <= 1'b1;
              state         <= DONE;
            end else begin
              rem         <= '0;
              quo         <= '0;
              bus.alu_req <= 1'b1;
              bus.alu_opc <= OPC_CMP;
              bus.alu_imm <= 1'b0;
              bus.alu_op1 <= {{(XLEN-1){1'b0}}, a_abs[XLEN-1]};
              bus.alu_op2 <= b_abs;
              state       <= CMP;
            end
          end
        end

        CMP, SUB: begin
          if (bus.alu_gnt) begin
            if (state == CMP && !cmp_lt) begin
              bus.alu_opc <= OPC_SUB;
              state       <= SUB;
            end else begin
              rem    <= step_rem;
              quo[i] <= step_qbit;
              if (i == '0) begin
                bus.alu_req <= 1'b0;
                state       <= FIX;
              end else begin
                i           <= nxt_i;
                bus.alu_op1 <= nxt_shift;
                // a carried-out bit means shifted >= 2^XLEN > divisor: subtract unconditionally
                if (nxt_carry) begin
                  bus.alu_opc <= OPC_SUB;
                  state       <= SUB;
                end else begin
                  bus.alu_opc <= OPC_CMP;
                  state       <= CMP;
                end
              end
            end
          end
        end

        FIX: begin
          bus.res       <= want_rem_q ? r_fix : q_fix;
          bus.res_valid <= 1'b1;
          state         <= DONE;
        end

        DONE: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq with a behavioural shared-ALU model and
// optional random grant; every result is checked against hand-computed values.
module tb_div_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_seq_if #(.XLEN(32)) bus ();

  div_seq #(.XLEN(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  bit          gnt_rand  = 1'b0;
  bit          mon_en    = 1'b0;
  bit          hold_prev = 1'b0;
  logic [31:0] sv_op1;
  logic [31:0] sv_op2;
  logic [5:0]  sv_opc;

  // Shared ALU: compare flags always valid, subtract result for opcode 0x04
  always_comb begin
    bus.alu_res    = (bus.alu_opc == 6'h04) ? (bus.alu_op1 - bus.alu_op2) : 32'h0;
    bus.alu_cmp[1] = (bus.alu_op1 < bus.alu_op2);
    bus.alu_cmp[0] = (bus.alu_op1 == bus.alu_op2);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Grant driver and stalled-command stability monitor
  initial begin
    bus.alu_gnt = 1'b1;
    forever begin
      @(negedge clk);
      if (hold_prev) begin
        check("hold_req", 32'(bus.alu_req), 32'd1);
        check("hold_op1", bus.alu_op1, sv_op1);
        check("hold_op2", bus.alu_op2, sv_op2);
        check("hold_opc", 32'(bus.alu_opc), 32'(sv_opc));
      end
      bus.alu_gnt = gnt_rand ? ($urandom_range(9, 0) < 3) : 1'b1;
      hold_prev   = mon_en && bus.alu_req && !bus.alu_gnt;
      sv_op1      = bus.alu_op1;
      sv_op2      = bus.alu_op2;
      sv_opc      = bus.alu_opc;
    end
  end

  // One request; lat_hi==0 skips the latency check, hold = cycles res_ready stays low
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic wr, input logic [31:0] exp,
                         input int unsigned lat_lo, input int unsigned lat_hi,
                         input int unsigned hold);
    int unsigned n;
    logic        req0;
    n = 0;
    while (!bus.start_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_start_ready"}, 32'(bus.start_ready), 32'd1);
    @(negedge clk);
    bus.dividend    = a;
    bus.divisor     = b;
    bus.is_signed   = sgn;
    bus.want_rem    = wr;
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    req0 = bus.alu_req;
    n = 1;
    while (!bus.res_valid && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
    check({tag, "_res"}, bus.res, exp);
    if (b == 32'h0) check({tag, "_no_alu_req"}, 32'(req0), 32'd0);
    if (lat_hi != 0) check({tag, "_latency_in_range"}, 32'(n >= lat_lo && n <= lat_hi), 32'd1);
    for (int unsigned k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(bus.res_valid), 32'd1);
      check({tag, "_hold_res"}, bus.res, exp);
      check({tag, "_hold_start_ready"}, 32'(bus.start_ready), 32'd0);
    end
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check({tag, "_after_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_after_start_ready"}, 32'(bus.start_ready), 32'd1);
  endtask

  initial begin
    bit seen;
    bus.start_valid = 1'b0;
    bus.dividend    = 32'h0;
    bus.divisor     = 32'h0;
    bus.is_signed   = 1'b0;
    bus.want_rem    = 1'b0;
    bus.flush       = 1'b0;
    bus.res_ready   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_alu_req", 32'(bus.alu_req), 32'd0);
    check("rst_res", bus.res, 32'h0);
    check("rst_alu_opc", 32'(bus.alu_opc), 32'd0);
    check("rst_alu_imm", 32'(bus.alu_imm), 32'd0);
    check("rst_alu_op1", bus.alu_op1, 32'h0);
    check("rst_alu_op2", bus.alu_op2, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_start_ready", 32'(bus.start_ready), 32'd1);

    // Full-grant directed vectors
    run_div("u100_7_q", 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 34, 66, 0);
    run_div("u100_7_r", 32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 34, 66, 0);
    run_div("s_m7_2_q", 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 32'hFFFFFFFD, 34, 66, 0);
    run_div("s_m7_2_r", 32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, 32'hFFFFFFFF, 34, 66, 0);
    run_div("s_min_m1_q", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000000, 34, 66, 0);
    run_div("s_min_m1_r", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0, 34, 66, 0);
    run_div("u_big_q", 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 32'd1, 34, 66, 0);
    run_div("u_big_r", 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b1, 32'd1, 34, 66, 0);
    run_div("u_all1_by1", 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 32'hFFFFFFFF, 34, 66, 0);
    run_div("div0_q", 32'h1234, 32'h0, 1'b0, 1'b0, 32'hFFFFFFFF, 1, 2, 0);
    run_div("div0_r", 32'h1234, 32'h0, 1'b0, 1'b1, 32'h1234, 1, 2, 0);

    // Result back-pressure
    run_div("bp_u100_7_r", 32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 34, 66, 5);

    // Random 30% grant with command-stability monitor
    gnt_rand = 1'b1;
    mon_en   = 1'b1;
    run_div("rg_u100_7_q", 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 0, 0, 0);
    run_div("rg_1e6_1000", 32'd1000000, 32'd1000, 1'b0, 1'b0, 32'd1000, 0, 0, 0);
    run_div("rg_12345_100_r", 32'd12345, 32'd100, 1'b0, 1'b1, 32'd45, 0, 0, 0);
    run_div("rg_s_m100_7_q", 32'hFFFFFF9C, 32'd7, 1'b1, 1'b0, 32'hFFFFFFF2, 0, 0, 0);
    run_div("rg_s_m100_7_r", 32'hFFFFFF9C, 32'd7, 1'b1, 1'b1, 32'hFFFFFFFE, 0, 0, 0);
    run_div("rg_s_7_m2_q", 32'd7, 32'hFFFFFFFE, 1'b1, 1'b0, 32'hFFFFFFFD, 0, 0, 0);
    run_div("rg_s_7_m2_r", 32'd7, 32'hFFFFFFFE, 1'b1, 1'b1, 32'd1, 0, 0, 0);
    mon_en   = 1'b0;
    gnt_rand = 1'b0;

    // Flush around bit 10 (0/7 retires one bit per cycle)
    @(negedge clk);
    bus.dividend    = 32'd0;
    bus.divisor     = 32'd7;
    bus.is_signed   = 1'b0;
    bus.want_rem    = 1'b0;
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    check("flush_pre_req", 32'(bus.alu_req), 32'd1);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_req", 32'(bus.alu_req), 32'd0);
    check("flush_valid", 32'(bus.res_valid), 32'd0);
    check("flush_idle", 32'(bus.start_ready), 32'd1);
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (bus.res_valid) seen = 1'b1;
    end
    check("flush_no_result", 32'(seen), 32'd0);
    run_div("post_flush", 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 34, 66, 0);

    // Flush wins over a simultaneous start
    @(negedge clk);
    bus.dividend    = 32'd100;
    bus.divisor     = 32'd7;
    bus.start_valid = 1'b1;
    bus.flush       = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    bus.flush       = 1'b0;
    check("flush_prio_idle", 32'(bus.start_ready), 32'd1);
    check("flush_prio_req", 32'(bus.alu_req), 32'd0);

    // Reset mid-operation discards the request
    @(negedge clk);
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(bus.alu_req), 32'd0);
    check("midrst_valid", 32'(bus.res_valid), 32'd0);
    check("midrst_op1", bus.alu_op1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (bus.res_valid) seen = 1'b1;
    end
    check("midrst_no_result", 32'(seen), 32'd0);
    check("midrst_start_ready", 32'(bus.start_ready), 32'd1);
    run_div("post_rst", 32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 34, 66, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the operand and result width; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports start_valid (in, 1) and start_ready (out, 1): the request handshake.
REQ-005 The block SHALL have ports dividend (in, 32), divisor (in, 32), is_signed (in, 1) and want_rem (in, 1): request operands, sampled on start handshake.
REQ-006 The block SHALL have port flush (in, 1): abort any operation in flight.
REQ-007 The block SHALL have ports res_valid (out, 1), res_ready (in, 1) and res (out, 32): the result handshake.
REQ-008 The block SHALL have ports alu_req (out, 1) and alu_gnt (in, 1): the shared-ALU arbitration handshake.
REQ-009 The block SHALL have ports alu_opc (out, 6), alu_imm (out, 1), alu_op1 (out, 32) and alu_op2 (out, 32): the ALU command.
REQ-010 The block SHALL have ports alu_res (in, 32) and alu_cmp (in, 2): ALU result and compare flags, indexed by alu_pkg EQ/LT, same cycle as the command.

Function
REQ-011 States SHALL be IDLE, CMP, SUB, FIX, DONE.
REQ-012 start_ready SHALL be 1 only in IDLE; start_valid&start_ready SHALL latch operands and go to IDLE->CMP with bit counter i=31, rem=0, quo=0.
REQ-013 Signed requests SHALL divide |dividend| by |divisor| (two's-complement negation done locally), then apply sign in FIX: quotient negated if signs differ, remainder takes dividend sign.
REQ-014 divisor==0 SHALL bypass iteration: IDLE->DONE next cycle, quotient 0xFFFFFFFF, remainder = original dividend, no ALU request.
REQ-015 Per bit: shifted = {rem[30:0], dvd[i]}; carry = rem[31] before shift.
REQ-016 CMP: alu_req=1, alu_opc=6'h05 (unsigned compare), alu_imm=0, op1=shifted, op2=|divisor|; entered with carry=1 SHALL skip directly to SUB with no ALU cycle.
REQ-017 On a granted CMP cycle: alu_cmp[LT]=1 -> quo[i]=0, rem=shifted, next bit (or FIX after i=0); else -> SUB.
REQ-018 SUB: alu_req=1, alu_opc=6'h04, op1=shifted, op2=|divisor|; on grant rem=alu_res (mod 2^32), quo[i]=1, next bit (or FIX after i=0).
REQ-019 Without alu_gnt the block SHALL hold state and keep the command stable; alu_req SHALL be 0 in IDLE, FIX and DONE.
REQ-020 FIX SHALL take one cycle, then DONE; res = want_rem ? remainder : quotient.
REQ-021 DONE: res_valid=1, res stable until res_valid&res_ready, then IDLE.
REQ-022 INT_MIN / -1 signed SHALL yield quotient 0x80000000, remainder 0 with no special case.
REQ-023 Latency from start handshake to res_valid SHALL be 34..66 cycles with permanent grant (32 bits of 1-2 ALU cycles, plus FIX, plus entry), and 2 cycles for divide-by-zero.
REQ-024 flush SHALL force IDLE next cycle from any state, dropping alu_req and res_valid; flush has priority over start and result handshakes in the same cycle.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, res_valid=0, alu_req=0, res=0, alu_opc=0, alu_op1=0, alu_op2=0, alu_imm=0, internal rem/quo/counter=0; start_ready=1 after release.
REQ-026 Reset assertion mid-operation SHALL discard the operation with no result delivered.

Verification
REQ-027 Unsigned 100/7, want_rem=0, gnt tied 1 -> res=14; want_rem=1 -> res=2.
REQ-028 Signed -7/2 -> quotient 0xFFFFFFFD; remainder 0xFFFFFFFF; INT_MIN/-1 -> 0x80000000, rem 0.
REQ-029 Unsigned 0xFFFFFFFF/0xFFFFFFFE (carry path) -> quotient 1, remainder 1; divisor 0 with dividend 0x1234 -> quotient 0xFFFFFFFF, rem 0x1234, res_valid 2 cycles after start.
REQ-030 alu_gnt random 30% duty -> results identical to full grant; command stable while req&!gnt.
REQ-031 flush asserted at bit 10 -> IDLE next cycle, alu_req=0, no res_valid; new request completes correctly.
REQ-032 res_ready held low 5 cycles in DONE -> res_valid and res stable; start_ready stays 0 until res handshake.
